cart_header_scan: RTL

// - Snoops the hps_io ROM download stream, captures the cartridge header
//   (serial 0x183-0x18A, checksum 0x18E, region 0x1F0-0x1F2), and walks a

---
 rtl/cart_header_scan.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cart_header_scan.sv
// Snoops the ROM download stream, captures the cartridge serial/region/checksum header and walks
// a serial table to raise quirk bits. Optional ROM checksum verification via ROM_CHECKSUM_EN.
module cart_header_scan #(
    parameter int                          NUM_QUIRKS  = 4,
    parameter int                          NUM_ENTRIES = 18,
    parameter logic [NUM_ENTRIES*64-1:0]   ENTRY_ID    = '0,
    parameter logic [NUM_ENTRIES*8-1:0]    ENTRY_QUIRK = '0
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [15:0]           ioctl_data,
    output logic [NUM_QUIRKS-1:0] quirks,
    output logic                  matched,
    output logic [7:0]            match_index,
    output logic                  region_valid,
    output logic [1:0]            region_code,
    output logic                  header_done,
    output logic                  checksum_done,
    output logic                  checksum_ok
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_MATCH   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [24:0] A_ID0  = 25'h182;
    localparam logic [24:0] A_ID1  = 25'h184;
    localparam logic [24:0] A_ID2  = 25'h186;
    localparam logic [24:0] A_ID3  = 25'h188;
    localparam logic [24:0] A_ID4  = 25'h18A;
    localparam logic [24:0] A_REG0 = 25'h1F0;
    localparam logic [24:0] A_REG1 = 25'h1F2;

    logic [63:0] entry_id    [NUM_ENTRIES];
    logic [7:0]  entry_quirk [NUM_ENTRIES];

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_tbl
        assign entry_id[g]    = ENTRY_ID[g*64 +: 64];
        assign entry_quirk[g] = ENTRY_QUIRK[g*8 +: 8];
    end

    logic [1:0]            state_q, state_d;
    logic                  old_dl_q, old_dl_d;
    logic [63:0]           id_q, id_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_QUIRKS-1:0] quirks_q, quirks_d;
    logic                  matched_q, matched_d;
    logic [7:0]            match_idx_q, match_idx_d;
    logic [7:0]            rb0_q, rb0_d, rb1_q, rb1_d, rb2_q, rb2_d;
    logic                  region_pend_q, region_pend_d;
    logic                  region_seen_q, region_seen_d;
    logic                  region_valid_q, region_valid_d;
    logic [1:0]            region_code_q, region_code_d;
    logic                  header_done_q, header_done_d;
    logic                  end_pend_q, end_pend_d;

    logic dl_rise, dl_fall, wr_en;
    assign dl_rise = ioctl_download & ~old_dl_q;
    assign dl_fall = ~ioctl_download & old_dl_q;
    assign wr_en   = ioctl_wr & ioctl_download;

    // Returns {valid, value} for an ASCII hex digit.
    function automatic logic [4:0] hex_digit(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= "0" && c <= "9")      r = {1'b1, 4'(c - "0")};
        else if (c >= "A" && c <= "F") r = {1'b1, 4'(c - "A" + 8'd10)};
        else if (c >= "a" && c <= "f") r = {1'b1, 4'(c - "a" + 8'd10)};
        return r;
    endfunction

    logic       dec_valid;
    logic [1:0] dec_code;
    logic [4:0] hx;
    logic       has_u, has_e, has_j;

    always_comb begin
        hx        = hex_digit(rb0_q);
        has_u     = (rb0_q == "U") || (rb1_q == "U") || (rb2_q == "U");
        has_e     = (rb0_q == "E") || (rb1_q == "E") || (rb2_q == "E");
        has_j     = (rb0_q == "J") || (rb1_q == "J") || (rb2_q == "J");
        dec_valid = 1'b1;
        dec_code  = 2'd0;
        if (has_u)                dec_code = 2'd1;
        else if (has_e)           dec_code = 2'd2;
        else if (has_j)           dec_code = 2'd0;
        else if (hx[4] && hx[2])  dec_code = 2'd1;
        else if (hx[4] && hx[3])  dec_code = 2'd2;
        else if (hx[4] && hx[0])  dec_code = 2'd0;
        else                      dec_valid = 1'b0;
    end

    logic       hit, walk_end, id_restart;
    logic [7:0] qsel;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can leave a latch behind.
        state_d        = state_q;
        old_dl_d       = ioctl_download;
        id_d           = id_q;
        idx_d          = idx_q;
        quirks_d       = quirks_q;
        matched_d      = matched_q;
        match_idx_d    = match_idx_q;
        rb0_d          = rb0_q;
        rb1_d          = rb1_q;
        rb2_d          = rb2_q;
        region_pend_d  = region_pend_q;
        region_seen_d  = region_seen_q;
        region_valid_d = region_valid_q;
        region_code_d  = region_code_q;
        header_done_d  = header_done_q;
        end_pend_d     = end_pend_q;
        hit            = (entry_id[idx_q] == id_q);
        qsel           = entry_quirk[idx_q];
        walk_end       = 1'b0;
        id_restart     = 1'b0;

        if (dl_rise) begin
            state_d        = ST_CAPTURE;
            id_d           = '0;
            idx_d          = '0;
            quirks_d       = '0;
            matched_d      = 1'b0;
            match_idx_d    = '0;
            rb0_d          = '0;
            rb1_d          = '0;
            rb2_d          = '0;
            region_pend_d  = 1'b0;
            region_seen_d  = 1'b0;
            region_valid_d = 1'b0;
            region_code_d  = '0;
            header_done_d  = 1'b0;
            end_pend_d     = 1'b0;
        end else begin
            if (region_pend_q) begin
                region_pend_d  = 1'b0;
                region_valid_d = dec_valid;
                region_code_d  = dec_code;
            end

            if (state_q == ST_MATCH) begin
                if (hit) begin
                    // Quirk indices beyond the vector still report the match.
                    for (int i = 0; i < NUM_QUIRKS; i++)
                        if (qsel == 8'(i)) quirks_d[i] = 1'b1;
                    matched_d   = 1'b1;
                    match_idx_d = 8'(idx_q);
                    walk_end    = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    walk_end = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (walk_end) begin
                    if (end_pend_q) begin
                        state_d       = ST_IDLE;
                        header_done_d = 1'b1;
                        end_pend_d    = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            if (state_q == ST_DONE && region_seen_q) header_done_d = 1'b1;

            if (wr_en && state_q != ST_IDLE) begin
                case (ioctl_addr)
                    A_ID0: begin
                        id_d[63:56] = ioctl_data[15:8];
                        id_restart  = (state_q == ST_MATCH) || (state_q == ST_DONE);
                    end
                    A_ID1: begin
                        id_d[55:40] = {ioctl_data[7:0], ioctl_data[15:8]};
                        id_restart  = (state_q == ST_MATCH) || (state_q == ST_DONE);
                    end
                    A_ID2: begin
                        id_d[39:24] = {ioctl_data[7:0], ioctl_data[15:8]};
                        id_restart  = (state_q == ST_MATCH) || (state_q == ST_DONE);
                    end
                    A_ID3: begin
                        id_d[23:8]  = {ioctl_data[7:0], ioctl_data[15:8]};
                        id_restart  = (state_q == ST_MATCH) || (state_q == ST_DONE);
                    end
                    A_ID4: begin
                        id_d[7:0]   = ioctl_data[7:0];
                        id_restart  = 1'b1;
                    end
                    A_REG0: begin
                        rb0_d = ioctl_data[7:0];
                        rb1_d = ioctl_data[15:8];
                    end
                    A_REG1: begin
                        rb2_d         = ioctl_data[7:0];
                        region_pend_d = 1'b1;
                        region_seen_d = 1'b1;
                    end
                    default: ;
                endcase
                if (id_restart) begin
                    state_d       = ST_MATCH;
                    idx_d         = '0;
                    quirks_d      = '0;
                    matched_d     = 1'b0;
                    match_idx_d   = '0;
                    header_done_d = 1'b0;
                end
            end

            // A walk still in flight finishes before header_done is raised.
            if (dl_fall) begin
                if (state_d == ST_MATCH) begin
                    end_pend_d = 1'b1;
                end else begin
                    state_d       = ST_IDLE;
                    header_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            old_dl_q       <= 1'b0;
            id_q           <= '0;
            idx_q          <= '0;
            quirks_q       <= '0;
            matched_q      <= 1'b0;
            match_idx_q    <= '0;
            rb0_q          <= '0;
            rb1_q          <= '0;
            rb2_q          <= '0;
            region_pend_q  <= 1'b0;
            region_seen_q  <= 1'b0;
            region_valid_q <= 1'b0;
            region_code_q  <= '0;
            header_done_q  <= 1'b0;
            end_pend_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge state.
            state_q        <= state_d;
            old_dl_q       <= old_dl_d;
            id_q           <= id_d;
            idx_q          <= idx_d;
            quirks_q       <= quirks_d;
            matched_q      <= matched_d;
            match_idx_q    <= match_idx_d;
            rb0_q          <= rb0_d;
            rb1_q          <= rb1_d;
            rb2_q          <= rb2_d;
            region_pend_q  <= region_pend_d;
            region_seen_q  <= region_seen_d;
            region_valid_q <= region_valid_d;
            region_code_q  <= region_code_d;
            header_done_q  <= header_done_d;
            end_pend_q     <= end_pend_d;
        end
    end

    assign quirks       = quirks_q;
    assign matched      = matched_q;
    assign match_index  = match_idx_q;
    assign region_valid = region_valid_q;
    assign region_code  = region_code_q;
    assign header_done  = header_done_q;

`ifdef ROM_CHECKSUM_EN
    localparam logic [24:0] A_SUM  = 25'h18E;
    localparam logic [24:0] A_BODY = 25'h200;

    logic [15:0] sum_q, sum_d, hdr_sum_q, hdr_sum_d, word;
    logic        ck_done_q, ck_done_d, ck_ok_q, ck_ok_d;

    assign word = {ioctl_data[7:0], ioctl_data[15:8]};

    always_comb begin
        sum_d     = sum_q;
        hdr_sum_d = hdr_sum_q;
        ck_done_d = ck_done_q;
        ck_ok_d   = ck_ok_q;
        if (dl_rise) begin
            sum_d     = '0;
            hdr_sum_d = '0;
            ck_done_d = 1'b0;
            ck_ok_d   = 1'b0;
        end else begin
            if (wr_en && ioctl_addr == A_SUM)  hdr_sum_d = word;
            if (wr_en && ioctl_addr >= A_BODY) sum_d     = sum_q + word;
            if (dl_fall) begin
                ck_ok_d   = (sum_q == hdr_sum_q);
                ck_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q     <= '0;
            hdr_sum_q <= '0;
            ck_done_q <= 1'b0;
            ck_ok_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            hdr_sum_q <= hdr_sum_d;
            ck_done_q <= ck_done_d;
            ck_ok_q   <= ck_ok_d;
        end
    end

    assign checksum_done = ck_done_q;
    assign checksum_ok   = ck_ok_q;
`else
    assign checksum_done = 1'b0;
    assign checksum_ok   = 1'b0;
`endif

endmodule
